tribus_arbiter: RTL and testbench
=================================

TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum owned cycles before preemption when another requester is pending; legal range 2..255.
REQ-002 Parameter TURN_CYCLES, default 1: dead cycles between owners with no output-enable asserted; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-005 req  input  4  per-requester bus request, level-sensitive, held while the requester wants the bus.
REQ-006 grant  output  4  one-hot ownership; all-zero when no owner.
REQ-007 oe  output  4  per-requester tri-state output-enable; registered; one-hot or zero.
REQ-008 owner  output  2  index of current or most recent owner.
REQ-009 busy  output  1  high while in OWN.
REQ-010 preempt  output  1  single-cycle pulse when ownership is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, OWN and TURN.
REQ-012 IDLE: grant=0, oe=0, busy=0; if any req bit is sampled high, the FSM SHALL select a winner and enter OWN on the same edge.
REQ-013 Winner selection SHALL be round-robin: search from (owner+1) mod 4 upward with wrap, and pick the first requester with req high.
REQ-014 Latency: req sampled high at edge k in IDLE -> grant[i] and oe[i] high after edge k; owner SHALL update on the same edge.
REQ-015 OWN: grant[i]=oe[i]=busy=1; an 8-bit hold counter SHALL start at 0 on entry and increment once per OWN cycle, saturating at HOLD_MAX-1.
REQ-016 OWN exit on release: req[owner] sampled low -> enter TURN; grant and oe SHALL be 0 after that edge; preempt SHALL stay 0.
REQ-017 OWN exit on preemption: counter == HOLD_MAX-1 and any other req bit high -> enter TURN and pulse preempt for exactly one cycle.
REQ-018 If the counter is saturated and no other requester is pending, the owner SHALL retain the bus indefinitely with no preempt pulse.
REQ-019 If release and preemption conditions occur together, the release SHALL take precedence and preempt SHALL stay 0.
REQ-020 TURN: grant=oe=busy=0 for exactly TURN_CYCLES cycles; a turnaround counter SHALL count them.
REQ-021 On the last TURN cycle: if any req bit is high, re-arbitrate per REQ-013 and enter OWN; otherwise enter IDLE.
REQ-022 A preempted owner still requesting SHALL be eligible again, but only after the other pending requesters in round-robin order.
REQ-023 At most one oe bit SHALL be high in any cycle, and oe SHALL never go directly from one requester to another without at least TURN_CYCLES zero cycles between them.
REQ-024 Requests that rise or fall during TURN SHALL affect only the arbitration on the final TURN cycle.

Reset
REQ-025 While rst is low at a rising edge, the block SHALL enter IDLE with grant=0, oe=0, busy=0, preempt=0, both counters=0 and owner=3, so that requester 0 has first priority.
REQ-026 Reset asserted during OWN or TURN SHALL take effect on that edge, zeroing oe on the following cycle regardless of req.
REQ-027 On the first edge with rst high, the block SHALL arbitrate normally from IDLE.

Verification
REQ-028 After reset, req=0110 -> grant=0010, owner=1, oe=0010 one cycle later; drop req[1] -> one zero cycle, then grant=0100.
REQ-029 From reset, req=1111 held continuously, HOLD_MAX=8 -> owners 0,1,2,3,0 in order, each owning 8 cycles, preempt pulses 4 times, and each handoff is separated by exactly 1 zero oe cycle.
REQ-030 req=0001 held alone for 20 cycles -> grant stays 0001 throughout, preempt never asserts, and busy=1.
REQ-031 Owner 2 drops req[2] on the same cycle its counter hits HOLD_MAX-1 while req[0] is high -> preempt=0, TURN, then grant=0001.
REQ-032 rst driven low mid-OWN (owner=1) -> next cycle oe=0000, owner=3; rst released with req=1010 -> grant=0010.
REQ-033 The bench SHALL check the REQ-023 invariant (oe one-hot or zero, and no direct owner-to-owner oe transition) on every cycle of all scenarios, with TURN_CYCLES=3 also exercised.

Source files
------------

// File: rtl/tribus_arbiter_if.sv
// Bus-side signal bundle for the four-requester tri-state arbiter.
// The master modport is the arbiter's view, and the slave modport is the requesters' view.
`timescale 1ns/1ps
interface tribus_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] oe;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  modport master (
    input  req,
    output grant,
    output oe,
    output owner,
    output busy,
    output preempt
  );

  modport slave (
    output req,
    input  grant,
    input  oe,
    input  owner,
    input  busy,
    input  preempt
  );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with four requesters.
// It has a hold-limit preemption and a guaranteed output-enable dead time between owners.
`timescale 1ns/1ps
module tribus_arbiter #(
  parameter int unsigned HOLD_MAX    = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  tribus_arbiter_if.master   bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] oe_q, oe_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] turn_q, turn_d;

  logic [1:0] winner_s;
  logic       any_req_s;
  logic       own_req_s;
  logic       others_req_s;

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    logic [3:0] base;
    base = 4'b0001;
    return base << idx;
  endfunction

  // Walk from the farthest candidate back to the nearest one so that the nearest requester wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx  = last + 2'(i);
      pick = r[idx] ? idx : pick;
    end
    return pick;
  endfunction

  assign winner_s     = rr_pick(owner_q, bus.req);
  assign any_req_s    = |bus.req;
  assign own_req_s    = bus.req[owner_q];
  assign others_req_s = |(bus.req & ~one_hot(owner_q));

  // Next-state and next-output computation for the IDLE/OWN/TURN controller.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = OWN;
          owner_d = winner_s;
          hold_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!own_req_s) begin
          // Release wins over a simultaneous hold-limit hit, so no preempt pulse is produced.
          state_d = TURN;
          turn_d  = 4'd0;
          hold_d  = 8'd0;
        end else if ((hold_q >= HOLD_LAST) && others_req_s) begin
          state_d   = TURN;
          turn_d    = 4'd0;
          hold_d    = 8'd0;
          preempt_d = 1'b1;
        end else begin
          state_d = OWN;
          hold_d  = (hold_q >= HOLD_LAST) ? hold_q : hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q >= TURN_LAST) begin
          turn_d = 4'd0;
          if (any_req_s) begin
            state_d = OWN;
            owner_d = winner_s;
            hold_d  = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 8'd0;
        turn_d  = 4'd0;
      end
    endcase

    grant_d = (state_d == OWN) ? one_hot(owner_d) : 4'b0000;
    oe_d    = (state_d == OWN) ? one_hot(owner_d) : 4'b0000;
    busy_d  = (state_d == OWN) ? 1'b1 : 1'b0;
  end

  // State, counter and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      oe_q      <= 4'b0000;
      owner_q   <= 2'd3;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= 8'd0;
      turn_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      oe_q      <= oe_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.oe      = oe_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter: two instances share one request vector.
// One instance uses TURN_CYCLES=1 and the other uses TURN_CYCLES=3, and the oe invariant is watched on both.
`timescale 1ns/1ps
module tb_tribus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rst_edge = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int inv_viol1 = 0;
  int inv_viol3 = 0;
  logic [3:0] last1 = 4'b0000;
  logic [3:0] last3 = 4'b0000;
  int zrun1 = 0;
  int zrun3 = 0;

  tribus_arbiter_if bus1();
  tribus_arbiter_if bus3();
  assign bus1.req = req;
  assign bus3.req = req;

  tribus_arbiter #(.HOLD_MAX(8), .TURN_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  tribus_arbiter #(.HOLD_MAX(8), .TURN_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (!rst_edge) begin
      last1 <= 4'b0000;
      zrun1 <= 0;
    end else begin
      if (($countones(bus1.oe) > 1) ||
          (bus1.oe !== 4'b0000 && last1 !== 4'b0000 && bus1.oe !== last1 && zrun1 < 1)) begin
        inv_viol1 <= inv_viol1 + 1;
        $display("FAIL oe_invariant_t1 @%0t: oe=%b prev_owner_oe=%b zero_cycles=%0d need>=1",
                 $time, bus1.oe, last1, zrun1);
      end
      if (bus1.oe !== 4'b0000) begin
        last1 <= bus1.oe;
        zrun1 <= 0;
      end else begin
        zrun1 <= zrun1 + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_edge) begin
      last3 <= 4'b0000;
      zrun3 <= 0;
    end else begin
      if (($countones(bus3.oe) > 1) ||
          (bus3.oe !== 4'b0000 && last3 !== 4'b0000 && bus3.oe !== last3 && zrun3 < 3)) begin
        inv_viol3 <= inv_viol3 + 1;
        $display("FAIL oe_invariant_t3 @%0t: oe=%b prev_owner_oe=%b zero_cycles=%0d need>=3",
                 $time, bus3.oe, last3, zrun3);
      end
      if (bus3.oe !== 4'b0000) begin
        last3 <= bus3.oe;
        zrun3 <= 0;
      end else begin
        zrun3 <= zrun3 + 1;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.oe, bus1.busy, bus1.preempt, bus1.owner} !== {4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3}) begin
      n_bad++;
      $display("FAIL reset_t1: grant=%b oe=%b busy=%b preempt=%b owner=%0d, expected 0000 0000 0 0 3",
               bus1.grant, bus1.oe, bus1.busy, bus1.preempt, bus1.owner);
    end
    n_cmp++;
    if ({bus3.oe, bus3.busy, bus3.owner} !== {4'b0000, 1'b0, 2'd3}) begin
      n_bad++;
      $display("FAIL reset_t3: oe=%b busy=%b owner=%0d, expected 0000 0 3", bus3.oe, bus3.busy, bus3.owner);
    end
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.busy, bus1.owner} !== {4'b0000, 1'b0, 2'd3}) begin
      n_bad++;
      $display("FAIL idle_no_req: grant=%b busy=%b owner=%0d, expected 0000 0 3", bus1.grant, bus1.busy, bus1.owner);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    req = 4'b0110;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.oe, bus1.owner, bus1.busy} !== {4'b0010, 4'b0010, 2'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL basic_first_grant: grant=%b oe=%b owner=%0d busy=%b, expected 0010 0010 1 1",
               bus1.grant, bus1.oe, bus1.owner, bus1.busy);
    end
    req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.oe, bus1.busy, bus1.preempt} !== {4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_turn: grant=%b oe=%b busy=%b preempt=%b, expected 0000 0000 0 0",
               bus1.grant, bus1.oe, bus1.busy, bus1.preempt);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.owner} !== {4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL basic_second_grant: grant=%b owner=%0d, expected 0100 2", bus1.grant, bus1.owner);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_oh;
    apply_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_oh = 4'b0001;
      exp_oh = exp_oh << (t % 4);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({bus1.grant, bus1.oe, bus1.preempt, bus1.owner} !== {exp_oh, exp_oh, 1'b0, 2'(t % 4)}) begin
          n_bad++;
          $display("FAIL rotation_own t=%0d c=%0d: grant=%b oe=%b preempt=%b owner=%0d, expected %b %b 0 %0d",
                   t, c, bus1.grant, bus1.oe, bus1.preempt, bus1.owner, exp_oh, exp_oh, t % 4);
        end
      end
      if (t < 4) begin
        @(negedge clk);
        n_cmp++;
        if ({bus1.oe, bus1.preempt, bus1.busy} !== {4'b0000, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL rotation_preempt t=%0d: oe=%b preempt=%b busy=%b, expected 0000 1 0",
                   t, bus1.oe, bus1.preempt, bus1.busy);
        end
      end
    end
  endtask

  task automatic test_single_hold();
    apply_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus1.grant, bus1.busy, bus1.preempt} !== {4'b0001, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL single_hold c=%0d: grant=%b busy=%b preempt=%b, expected 0001 1 0",
                 c, bus1.grant, bus1.busy, bus1.preempt);
      end
    end
    req = 4'b0101;
    @(negedge clk);
    n_cmp++;
    if ({bus1.oe, bus1.preempt} !== {4'b0000, 1'b1}) begin
      n_bad++;
      $display("FAIL saturated_preempt: oe=%b preempt=%b, expected 0000 1", bus1.oe, bus1.preempt);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.owner, bus1.preempt} !== {4'b0100, 2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL saturated_next_owner: grant=%b owner=%0d preempt=%b, expected 0100 2 0",
               bus1.grant, bus1.owner, bus1.preempt);
    end
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.busy, bus1.preempt} !== {4'b0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL back_to_idle: grant=%b busy=%b preempt=%b, expected 0000 0 0", bus1.grant, bus1.busy, bus1.preempt);
    end
  endtask

  task automatic test_release_precedence();
    apply_reset();
    req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.owner} !== {4'b0100, 2'd2}) begin
      n_bad++;
      $display("FAIL prec_grant: grant=%b owner=%0d, expected 0100 2", bus1.grant, bus1.owner);
    end
    req = 4'b0101;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus1.grant, bus1.preempt} !== {4'b0100, 1'b0}) begin
        n_bad++;
        $display("FAIL prec_hold c=%0d: grant=%b preempt=%b, expected 0100 0", c, bus1.grant, bus1.preempt);
      end
    end
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.oe, bus1.preempt, bus1.busy} !== {4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL prec_release: grant=%b oe=%b preempt=%b busy=%b, expected 0000 0000 0 0",
               bus1.grant, bus1.oe, bus1.preempt, bus1.busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.owner} !== {4'b0001, 2'd0}) begin
      n_bad++;
      $display("FAIL prec_next: grant=%b owner=%0d, expected 0001 0", bus1.grant, bus1.owner);
    end
  endtask

  task automatic test_reset_mid_own();
    apply_reset();
    req = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.owner} !== {4'b0010, 2'd1}) begin
      n_bad++;
      $display("FAIL midrst_own: grant=%b owner=%0d, expected 0010 1", bus1.grant, bus1.owner);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus1.oe, bus1.grant, bus1.owner, bus1.busy, bus1.preempt} !== {4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_cleared: oe=%b grant=%b owner=%0d busy=%b preempt=%b, expected 0000 0000 3 0 0",
               bus1.oe, bus1.grant, bus1.owner, bus1.busy, bus1.preempt);
    end
    rst = 1'b1;
    req = 4'b1010;
    @(negedge clk);
    n_cmp++;
    if ({bus1.grant, bus1.oe, bus1.owner} !== {4'b0010, 4'b0010, 2'd1}) begin
      n_bad++;
      $display("FAIL midrst_rearb: grant=%b oe=%b owner=%0d, expected 0010 0010 1", bus1.grant, bus1.oe, bus1.owner);
    end
  endtask

  task automatic test_turn3();
    apply_reset();
    req = 4'b0011;
    @(negedge clk);
    n_cmp++;
    if ({bus3.grant, bus3.owner} !== {4'b0001, 2'd0}) begin
      n_bad++;
      $display("FAIL t3_first: grant=%b owner=%0d, expected 0001 0", bus3.grant, bus3.owner);
    end
    req = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if ({bus3.oe, bus3.busy, bus3.preempt} !== {4'b0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL t3_turn1: oe=%b busy=%b preempt=%b, expected 0000 0 0", bus3.oe, bus3.busy, bus3.preempt);
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (bus3.oe !== 4'b0000) begin
      n_bad++;
      $display("FAIL t3_turn2: oe=%b, expected 0000", bus3.oe);
    end
    req = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if ({bus3.oe, bus3.busy} !== {4'b0000, 1'b0}) begin
      n_bad++;
      $display("FAIL t3_turn3: oe=%b busy=%b, expected 0000 0", bus3.oe, bus3.busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus3.grant, bus3.owner} !== {4'b1000, 2'd3}) begin
      n_bad++;
      $display("FAIL t3_late_req: grant=%b owner=%0d, expected 1000 3", bus3.grant, bus3.owner);
    end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus3.oe, bus3.busy} !== {4'b0000, 1'b0}) begin
        n_bad++;
        $display("FAIL t3_drain c=%0d: oe=%b busy=%b, expected 0000 0", c, bus3.oe, bus3.busy);
      end
    end
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if ({bus3.grant, bus3.owner} !== {4'b0001, 2'd0}) begin
      n_bad++;
      $display("FAIL t3_from_idle: grant=%b owner=%0d, expected 0001 0", bus3.grant, bus3.owner);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    test_reset();
    test_basic();
    test_rotation();
    test_single_hold();
    test_release_precedence();
    test_reset_mid_own();
    test_turn3();
    @(negedge clk);
    n_cmp++;
    if (inv_viol1 !== 0) begin
      n_bad++;
      $display("FAIL oe_invariant_total_t1: violations=%0d, expected 0", inv_viol1);
    end
    n_cmp++;
    if (inv_viol3 !== 0) begin
      n_bad++;
      $display("FAIL oe_invariant_total_t3: violations=%0d, expected 0", inv_viol3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
